// File: rtl/tcdm_mem_responder.sv
// Single-port TCDM slave bank answering hwpe_stream_intf_tcdm masters with
// fixed-latency in-order responses, byte-enable writes and access statistics.
module tcdm_mem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        stall_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] add_i,
    input  logic        wen_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] data_i,
    output logic [31:0] r_data_o,
    output logic        r_valid_o,
    output logic        err_o,
    output logic [31:0] n_reads_o,
    output logic [31:0] n_writes_o
);

    localparam int unsigned AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] SPAN = {1'b0, 32'(MEM_WORDS)} << 2;

    logic [31:0] mem_r [MEM_WORDS];

    logic [32:0] diff_s;
    logic        in_range_s;
    logic [AW-1:0] idx_s;
    logic        accept_s;
    logic [31:0] rd_word_s;

    logic        pipe_valid_r [LATENCY];
    logic [31:0] pipe_data_r  [LATENCY];

    // Grant, address decode and read sampling.
    // A below-base address wraps the 33-bit difference high, so one compare covers both bounds.
    always_comb begin
        gnt_o      = req_i & ~stall_i;
        accept_s   = req_i & gnt_o;
        diff_s     = {1'b0, add_i} - {1'b0, BASE_ADDR};
        in_range_s = (diff_s < SPAN);
        idx_s      = diff_s[AW+1:2];
        if (accept_s && wen_i && in_range_s) begin
            rd_word_s = mem_r[idx_s];
        end else begin
            rd_word_s = 32'h0000_0000;
        end
    end

    // Storage array: byte-enabled writes, never reset.
    // Writes land even in a clear cycle; only the response and statistics are suppressed.
    always_ff @(posedge clk_i) begin
        if (accept_s && !wen_i && in_range_s) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem_r[idx_s][8*k +: 8] <= data_i[8*k +: 8];
                end
            end
        end
    end

    // Fixed-latency response shift register; writes carry zero data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < int'(LATENCY); s++) begin
                pipe_valid_r[s] <= 1'b0;
                pipe_data_r[s]  <= 32'h0000_0000;
            end
        end else if (clear_i) begin
            for (int s = 0; s < int'(LATENCY); s++) begin
                pipe_valid_r[s] <= 1'b0;
                pipe_data_r[s]  <= 32'h0000_0000;
            end
        end else begin
            pipe_valid_r[0] <= accept_s;
            pipe_data_r[0]  <= rd_word_s;
            for (int s = 1; s < int'(LATENCY); s++) begin
                pipe_valid_r[s] <= pipe_valid_r[s-1];
                pipe_data_r[s]  <= pipe_data_r[s-1];
            end
        end
    end

    assign r_valid_o = pipe_valid_r[LATENCY-1];
    assign r_data_o  = pipe_data_r[LATENCY-1];

    // Sticky range error and saturating access counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o      <= 1'b0;
            n_reads_o  <= 32'h0000_0000;
            n_writes_o <= 32'h0000_0000;
        end else if (clear_i) begin
            err_o      <= 1'b0;
            n_reads_o  <= 32'h0000_0000;
            n_writes_o <= 32'h0000_0000;
        end else begin
            if (accept_s && !in_range_s) begin
                err_o <= 1'b1;
            end
            if (accept_s && wen_i && (n_reads_o != 32'hFFFF_FFFF)) begin
                n_reads_o <= n_reads_o + 32'd1;
            end
            if (accept_s && !wen_i && (n_writes_o != 32'hFFFF_FFFF)) begin
                n_writes_o <= n_writes_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_tcdm_mem_responder.sv
// Directed bench: three banks (LATENCY 1, 3, 4) share one request stream,
// each checked against hand-computed responses.
module tb_tcdm_mem_responder;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int unsigned WORDS = 64;

    logic        clk_i;
    logic        rst_ni;
    logic        clear_i;
    logic        stall_i;
    logic        req_i;
    logic [31:0] add_i;
    logic        wen_i;
    logic [3:0]  be_i;
    logic [31:0] data_i;

    logic        gnt_s     [3];
    logic [31:0] r_data_s  [3];
    logic        r_valid_s [3];
    logic        err_s     [3];
    logic [31:0] n_reads_s [3];
    logic [31:0] n_writes_s[3];

    int n_pass  = 0;
    int n_total = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tcdm_mem_responder #(
            .MEM_WORDS(WORDS),
            .LATENCY  ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .BASE_ADDR(BASE)
        ) u_dut (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .clear_i   (clear_i),
            .stall_i   (stall_i),
            .req_i     (req_i),
            .gnt_o     (gnt_s[g]),
            .add_i     (add_i),
            .wen_i     (wen_i),
            .be_i      (be_i),
            .data_i    (data_i),
            .r_data_o  (r_data_s[g]),
            .r_valid_o (r_valid_s[g]),
            .err_o     (err_s[g]),
            .n_reads_o (n_reads_s[g]),
            .n_writes_o(n_writes_s[g])
        );
    end

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_i = 1'b1; wen_i = 1'b0; add_i = a; data_i = d; be_i = be;
    endtask

    task automatic set_rd(input logic [31:0] a);
        req_i = 1'b1; wen_i = 1'b1; add_i = a; data_i = 32'h0000_0000; be_i = 4'h0;
    endtask

    task automatic idle();
        req_i = 1'b0; wen_i = 1'b1; add_i = 32'h0000_0000; data_i = 32'h0000_0000; be_i = 4'h0;
    endtask

    initial begin
        logic        v_exp;
        logic [31:0] d_exp;
        int          lat;

        rst_ni = 1'b0; clear_i = 1'b0; stall_i = 1'b0;
        idle();
        repeat (2) @(negedge clk_i);

        // reset state
        for (int g = 0; g < 3; g += 2) begin
            chk($sformatf("rst_valid%0d", g), 32'(r_valid_s[g]), 32'h0);
            chk($sformatf("rst_data%0d", g), r_data_s[g], 32'h0);
            chk($sformatf("rst_err%0d", g), 32'(err_s[g]), 32'h0);
            chk($sformatf("rst_nrd%0d", g), n_reads_s[g], 32'h0);
            chk($sformatf("rst_nwr%0d", g), n_writes_s[g], 32'h0);
        end
        set_rd(BASE);
        #1 chk("rst_gnt", 32'(gnt_s[0]), 32'h1);
        idle();
        @(negedge clk_i) rst_ni = 1'b1;

        // write then read the same word back-to-back
        set_wr(BASE + 32'h10, 32'hA5A5_1234, 4'hF);
        @(negedge clk_i);
        chk("t1_wr_valid", 32'(r_valid_s[0]), 32'h1);
        chk("t1_wr_data", r_data_s[0], 32'h0);
        set_rd(BASE + 32'h10);
        @(negedge clk_i);
        chk("t1_rd_valid", 32'(r_valid_s[0]), 32'h1);
        chk("t1_rd_data", r_data_s[0], 32'hA5A5_1234);
        chk("t1_nwr", n_writes_s[0], 32'd1);
        chk("t1_nrd", n_reads_s[0], 32'd1);
        idle();
        @(negedge clk_i);
        chk("t1_idle_valid", 32'(r_valid_s[0]), 32'h0);
        chk("t1_idle_data", r_data_s[0], 32'h0);

        // clear flushes the LATENCY=4 pipe that still holds two responses
        clear_i = 1'b1;
        @(negedge clk_i) clear_i = 1'b0;
        chk("clr_nrd4", n_reads_s[2], 32'h0);
        chk("clr_nwr4", n_writes_s[2], 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("clr_flush4_%0d", i), 32'(r_valid_s[2]), 32'h0);
            @(negedge clk_i);
        end

        // byte enables, including an all-zero enable no-op
        set_wr(BASE, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk_i) set_wr(BASE, 32'h0000_0000, 4'b0101);
        @(negedge clk_i) set_wr(BASE, 32'h1234_5678, 4'b0000);
        @(negedge clk_i) set_rd(BASE);
        @(negedge clk_i) idle();
        chk("t2_valid", 32'(r_valid_s[0]), 32'h1);
        chk("t2_be_data", r_data_s[0], 32'hFF00_FF00);
        chk("t2_nwr", n_writes_s[0], 32'd3);
        chk("t2_nrd", n_reads_s[0], 32'd1);

        // preload words 0..7 with i*0x11, then 8 back-to-back reads
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i) set_wr(BASE + 32'(4 * k), 32'(k * 17), 4'hF);
        end
        @(negedge clk_i) idle();
        repeat (5) @(negedge clk_i);
        for (int j = 0; j < 13; j++) begin
            @(negedge clk_i);
            for (int g = 0; g < 3; g++) begin
                lat   = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
                v_exp = (j >= lat) && (j <= lat + 7);
                d_exp = v_exp ? 32'((j - lat) * 17) : 32'h0;
                chk($sformatf("t3_valid_l%0d_c%0d", lat, j), 32'(r_valid_s[g]), 32'(v_exp));
                chk($sformatf("t3_data_l%0d_c%0d", lat, j), r_data_s[g], d_exp);
            end
            if (j < 8) set_rd(BASE + 32'(4 * j));
            else idle();
        end
        chk("t3_nrd", n_reads_s[1], 32'd9);
        chk("t3_nwr", n_writes_s[1], 32'd11);

        // stall with request held
        stall_i = 1'b1;
        set_rd(BASE + 32'h14);
        #1 chk("t4_gnt_stall0", 32'(gnt_s[0]), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk_i);
            chk($sformatf("t4_gnt_stall%0d", i), 32'(gnt_s[0]), 32'h0);
            chk($sformatf("t4_novalid%0d", i), 32'(r_valid_s[0]), 32'h0);
            chk($sformatf("t4_nrd%0d", i), n_reads_s[0], 32'd9);
        end
        stall_i = 1'b0;
        #1 chk("t4_gnt_release", 32'(gnt_s[0]), 32'h1);
        @(negedge clk_i) idle();
        chk("t4_valid", 32'(r_valid_s[0]), 32'h1);
        chk("t4_data", r_data_s[0], 32'h55);
        chk("t4_nrd_after", n_reads_s[0], 32'd10);
        @(negedge clk_i);
        chk("t4_single", 32'(r_valid_s[0]), 32'h0);

        // out-of-range accesses
        set_rd(BASE + 32'(4 * WORDS));
        #1 chk("t5_gnt", 32'(gnt_s[0]), 32'h1);
        @(negedge clk_i) set_wr(BASE + 32'(4 * WORDS), 32'hDEAD_BEEF, 4'hF);
        chk("t5_valid", 32'(r_valid_s[0]), 32'h1);
        chk("t5_data", r_data_s[0], 32'h0);
        chk("t5_err", 32'(err_s[0]), 32'h1);
        @(negedge clk_i) set_rd(BASE - 32'h4);
        chk("t5_err_sticky", 32'(err_s[0]), 32'h1);
        @(negedge clk_i) set_rd(BASE);
        chk("t5_below_valid", 32'(r_valid_s[0]), 32'h1);
        chk("t5_below_data", r_data_s[0], 32'h0);
        @(negedge clk_i) idle();
        chk("t5_no_alias", r_data_s[0], 32'h0);
        chk("t5_nrd", n_reads_s[0], 32'd13);
        chk("t5_nwr", n_writes_s[0], 32'd12);

        // clear with a write accepted in the same cycle
        set_wr(BASE + 32'h18, 32'h6666_0000, 4'hF);
        clear_i = 1'b1;
        @(negedge clk_i) clear_i = 1'b0;
        idle();
        chk("t5_clr_err", 32'(err_s[0]), 32'h0);
        chk("t5_clr_nrd", n_reads_s[0], 32'h0);
        chk("t5_clr_nwr", n_writes_s[0], 32'h0);
        chk("t5_clr_noresp", 32'(r_valid_s[0]), 32'h0);

        // async reset with three reads in flight on the LATENCY=4 bank
        @(negedge clk_i) set_rd(BASE + 32'h4);
        @(negedge clk_i) set_rd(BASE + 32'h8);
        @(negedge clk_i) set_rd(BASE + 32'hC);
        @(negedge clk_i) idle();
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_valid4", 32'(r_valid_s[2]), 32'h0);
        chk("t6_rst_data4", r_data_s[2], 32'h0);
        chk("t6_rst_nrd4", n_reads_s[2], 32'h0);
        chk("t6_rst_valid1", 32'(r_valid_s[0]), 32'h0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            chk($sformatf("t6_quiet%0d", i), 32'(r_valid_s[2]), 32'h0);
        end
        set_rd(BASE + 32'h18);
        @(negedge clk_i) set_rd(BASE + 32'h1C);
        chk("t6_mem_w6", r_data_s[0], 32'h6666_0000);
        @(negedge clk_i) idle();
        chk("t6_mem_w7", r_data_s[0], 32'h77);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
